// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for one shared external 2-bit divider.
// Divide-by-zero requests skip the divider, complete in one cycle and are counted.
module div_arbiter #(
    parameter int EVAL_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] n0,
    input  logic [1:0] d0,
    input  logic [1:0] n1,
    input  logic [1:0] d1,
    output logic [1:0] ack,
    output logic [1:0] q,
    output logic [1:0] r,
    output logic       dz,
    output logic       busy,
    output logic [1:0] div_n,
    output logic [1:0] div_d,
    input  logic [1:0] div_q,
    input  logic [1:0] div_r,
    output logic [3:0] dz_cnt
);

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t     state;
    logic       rr;
    logic       gnt;
    logic       pick;
    logic [2:0] cnt;
    logic [1:0] sel_n;
    logic [1:0] sel_d;

    // With both requests pending the pointer decides; otherwise the lone requester wins.
    always_comb begin
        pick  = (req == 2'b11) ? rr : req[1];
        sel_n = pick ? n1 : n0;
        sel_d = pick ? d1 : d0;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr     <= 1'b0;
            gnt    <= 1'b0;
            cnt    <= 3'd0;
            ack    <= 2'b00;
            q      <= 2'b00;
            r      <= 2'b00;
            dz     <= 1'b0;
            div_n  <= 2'b00;
            div_d  <= 2'b00;
            dz_cnt <= 4'd0;
        end else begin
            ack <= 2'b00;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        gnt <= pick;
                        rr  <= ~pick;
                        // Zero divisor never touches the divider operands.
                        if (sel_d == 2'b00) begin
                            state <= DONE;
                            ack   <= {pick, ~pick};
                            q     <= 2'b00;
                            r     <= 2'b00;
                            dz    <= 1'b1;
                            if (dz_cnt != 4'hF) dz_cnt <= dz_cnt + 4'd1;
                        end else begin
                            state <= EVAL;
                            cnt   <= 3'd0;
                            div_n <= sel_n;
                            div_d <= sel_d;
                        end
                    end
                end
                EVAL: begin
                    if (cnt == 3'(EVAL_CYCLES - 1)) begin
                        state <= DONE;
                        ack   <= {gnt, ~gnt};
                        q     <= div_q;
                        r     <= div_r;
                        dz    <= 1'b0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Randomized bench for div_arbiter: a transaction-level timing model predicts every
// output each cycle; directed passes cover reset, divide-by-zero saturation and EVAL_CYCLES=3.
module tb_div_arbiter;

    localparam int E1 = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req, n0, d0, n1, d1;
    logic [1:0] ack, q, r, div_n, div_d, div_q, div_r;
    logic       dz, busy;
    logic [3:0] dz_cnt;

    logic [1:0] req3, n03, d03, n13, d13;
    logic [1:0] ack3, q3, r3, div_n3, div_d3, div_q3, div_r3;
    logic       dz3, busy3;
    logic [3:0] dz_cnt3;

    always #5 clk = ~clk;

    // External combinational dividers.
    assign div_q  = (div_d == 2'b00) ? 2'b00 : div_n / div_d;
    assign div_r  = (div_d == 2'b00) ? 2'b00 : div_n % div_d;
    assign div_q3 = (div_d3 == 2'b00) ? 2'b00 : div_n3 / div_d3;
    assign div_r3 = (div_d3 == 2'b00) ? 2'b00 : div_n3 % div_d3;

    div_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .n0(n0), .d0(d0), .n1(n1), .d1(d1),
        .ack(ack), .q(q), .r(r), .dz(dz), .busy(busy), .div_n(div_n), .div_d(div_d),
        .div_q(div_q), .div_r(div_r), .dz_cnt(dz_cnt)
    );

    div_arbiter #(.EVAL_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .n0(n03), .d0(d03), .n1(n13), .d1(d13),
        .ack(ack3), .q(q3), .r(r3), .dz(dz3), .busy(busy3), .div_n(div_n3), .div_d(div_d3),
        .div_q(div_q3), .div_r(div_r3), .dz_cnt(dz_cnt3)
    );

    int total = 0;
    int bad   = 0;

    // Transaction-level model: times are posedge indices.
    int pe;
    int free_at, ack_at, busy_from, who_m, rr_m;
    int q_m, r_m, dz_m, dzc_m, dn_m, dd_m;
    int pq, pr, pdz;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        free_at = 0; ack_at = -100; busy_from = -100; who_m = 0; rr_m = 0;
        q_m = 0; r_m = 0; dz_m = 0; dzc_m = 0; dn_m = 0; dd_m = 0;
        pq = 0; pr = 0; pdz = 0;
    endtask

    task automatic predict();
        int who, nn, dd;
        if (pe >= free_at && req != 2'b00) begin
            who  = (req == 2'b11) ? rr_m : (req[1] ? 1 : 0);
            rr_m = 1 - who;
            nn   = who ? int'(n1) : int'(n0);
            dd   = who ? int'(d1) : int'(d0);
            busy_from = pe;
            who_m     = who;
            if (dd == 0) begin
                ack_at = pe;
                pq = 0; pr = 0; pdz = 1;
                if (dzc_m < 15) dzc_m++;
            end else begin
                ack_at = pe + E1;
                pq = nn / dd; pr = nn % dd; pdz = 0;
                dn_m = nn; dd_m = dd;
            end
            free_at = ack_at + 2;
        end
    endtask

    task automatic compare(output logic [1:0] ea);
        int eb;
        ea = 2'b00;
        if (pe == ack_at) begin
            ea = (who_m == 1) ? 2'b10 : 2'b01;
            q_m = pq; r_m = pr; dz_m = pdz;
        end
        eb = (pe >= busy_from && pe <= ack_at) ? 1 : 0;
        check("ack", ack, ea);
        check("busy", busy, eb);
        check("q", q, q_m);
        check("r", r, r_m);
        check("dz", dz, dz_m);
        check("dz_cnt", dz_cnt, dzc_m);
        check("div_n", div_n, dn_m);
        check("div_d", div_d, dd_m);
    endtask

    task automatic tick(input bit rnd, output logic [1:0] ea);
        pe++;
        predict();
        @(negedge clk);
        compare(ea);
        for (int i = 0; i < 2; i++) begin
            if (ea[i])
                req[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            else if (rnd && !req[i] && $urandom_range(0, 2) == 0)
                req[i] = 1'b1;
        end
        if (rnd) begin
            n0 = 2'($urandom); d0 = 2'($urandom);
            n1 = 2'($urandom); d1 = 2'($urandom);
        end
    endtask

    // Called at a falling edge: asserts reset mid-cycle, checks outputs, releases before the next rise+1.
    task automatic do_reset();
        logic [1:0] ea;
        #2 rst_n = 1'b0;
        req = 2'b00;
        #1 reset_model();
        compare(ea);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] ea;
        int seen;
        rst_n = 1'b0;
        req = 2'b00; n0 = 2'b00; d0 = 2'b00; n1 = 2'b00; d1 = 2'b00;
        req3 = 2'b00; n03 = 2'b00; d03 = 2'b00; n13 = 2'b00; d13 = 2'b00;
        pe = 0;
        reset_model();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Single request 3/1.
        req = 2'b01; n0 = 2'd3; d0 = 2'd1;
        repeat (4) tick(1'b0, ea);

        // Simultaneous requests from rr = 0.
        req = 2'b11; n0 = 2'd2; d0 = 2'd1; n1 = 2'd3; d1 = 2'd2;
        repeat (8) tick(1'b0, ea);

        // Divide by zero on requester 1.
        req = 2'b10; n1 = 2'd2; d1 = 2'd0;
        repeat (3) tick(1'b0, ea);

        // Reset while in EVAL, then quiet for 10 cycles.
        req = 2'b01; n0 = 2'd1; d0 = 2'd1;
        tick(1'b0, ea);
        do_reset();
        repeat (10) tick(1'b0, ea);

        // Randomized traffic.
        repeat (2000) tick(1'b1, ea);

        // Saturation of the divide-by-zero counter, starting from reset.
        req = 2'b00;
        repeat (3) tick(1'b0, ea);
        do_reset();
        for (int t = 1; t <= 16; t++) begin
            req = 2'b10; n1 = 2'($urandom); d1 = 2'd0;
            seen = 0;
            for (int c = 0; c < 8 && seen == 0; c++) begin
                tick(1'b0, ea);
                if (ea != 2'b00) seen = 1;
            end
            check("dz_done", seen, 1);
            if (t == 15) check("sat15", dz_cnt, 15);
            if (t == 16) check("sat16", dz_cnt, 15);
            tick(1'b0, ea);
        end

        // EVAL_CYCLES = 3 instance: 3/2 acked on the fourth cycle.
        req3 = 2'b01; n03 = 2'd3; d03 = 2'd2;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req3 = 2'b01; n03 = 2'd0; d03 = 2'd1;
                check("e3_div_n", div_n3, 3);
                check("e3_div_d", div_d3, 2);
            end
            check("e3_ack", ack3, (c == 4) ? 1 : 0);
            check("e3_busy", busy3, 1);
            if (c == 4) begin
                check("e3_q", q3, 1);
                check("e3_r", r3, 1);
                check("e3_dz", dz3, 0);
                req3 = 2'b00;
            end
        end
        @(negedge clk);
        check("e3_ack_clear", ack3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter EVAL_CYCLES, default 1 (legal 1..7), giving the number of cycles the shared 2-bit divider is allowed to settle.

Ports:
REQ-002 The block SHALL have port clk, input, 1, the single clock, rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, 2, per-requester request; req[i] is held high until ack[i].
REQ-005 The block SHALL have ports n0, d0, n1, d1, input, 2 each, dividend and divisor of requester 0 and requester 1.
REQ-006 The block SHALL have port ack, output, 2, one-cycle completion pulse per requester.
REQ-007 The block SHALL have ports q and r, output, 2 each, quotient and remainder, valid while ack != 0.
REQ-008 The block SHALL have port dz, output, 1, divide-by-zero flag, valid while ack != 0.
REQ-009 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 The block SHALL have ports div_n and div_d, output, 2 each, operands driven to the external combinational 2-bit divider.
REQ-011 The block SHALL have ports div_q and div_r, input, 2 each, results returned by that divider.
REQ-012 The block SHALL have port dz_cnt, output, 4, saturating count of divide-by-zero transactions.

Function
REQ-013 The FSM SHALL have states IDLE, EVAL and DONE, with exactly one transaction in flight.
REQ-014 In IDLE with req == 0, the block SHALL remain in IDLE.
REQ-015 In IDLE with any req bit high, the block SHALL grant one requester and register its n/d into div_n/div_d at that edge.
REQ-016 Arbitration SHALL be round-robin via pointer rr: if both requests are high, grant rr; if one is high, grant that one.
REQ-017 After each grant, rr SHALL point to the non-granted index.
REQ-018 A granted transaction with d != 0 SHALL go to EVAL, stay there exactly EVAL_CYCLES cycles, and then go to DONE.
REQ-019 q and r SHALL be registered from div_q/div_r on the EVAL-to-DONE edge.
REQ-020 A granted transaction with d == 0 SHALL go directly from IDLE to DONE and SHALL NOT enter EVAL.
REQ-021 For a d == 0 transaction: q = 0, r = 0, dz = 1, and dz_cnt increments by 1, saturating at 15.
REQ-022 In DONE, the block SHALL assert ack[granted] = 1 and the other ack bit = 0, for exactly one cycle, then return to IDLE.
REQ-023 Latency, counted from the IDLE edge that samples req:
  - normal transaction: ack is high in cycle EVAL_CYCLES + 1 (2 cycles at default);
  - d == 0 transaction: ack is high in cycle 1.
REQ-024 Back-to-back requests: a req still high in the cycle after ack SHALL be treated as a new request, arbitrated in IDLE.
REQ-025 Operand changes on n*/d* after the grant edge SHALL have no effect on the transaction in flight.
REQ-026 A request arriving while busy = 1 SHALL wait; it SHALL NOT be dropped or reordered.
REQ-027 q, r and dz SHALL hold their last values outside DONE; ack SHALL be 0 outside DONE.
REQ-028 div_n and div_d SHALL hold the granted operands until the next grant.
REQ-029 A d == 0 transaction SHALL leave div_n/div_d at their previous values.

Reset
REQ-030 When rst_n = 0, the block SHALL immediately, independent of clk, set:
  - state = IDLE, rr = 0;
  - ack = 0, q = 0, r = 0, dz = 0, busy = 0;
  - div_n = 0, div_d = 0, dz_cnt = 0.
REQ-031 A transaction interrupted by reset SHALL be dropped, with no ack issued after reset release.
REQ-032 The first IDLE edge after rst_n rises SHALL arbitrate normally.

Verification
REQ-033 Single request: req = 01, n0 = 3, d0 = 1 -> ack = 01 two cycles later, q = 3, r = 0, dz = 0, busy high for 2 cycles.
REQ-034 Simultaneous requests, from reset (rr = 0): req = 11, n0 = 2, d0 = 1, n1 = 3, d1 = 2, both held until their own ack -> ack = 01 with q = 2, r = 0; then ack = 10 with q = 1, r = 1, issued 3 cycles after the first ack.
REQ-035 Divide by zero: req = 10, n1 = 2, d1 = 0 -> ack = 10 one cycle later, q = 0, r = 0, dz = 1, dz_cnt = 1, div_n/div_d unchanged.
REQ-036 Reset mid-operation: rst_n pulsed low during EVAL -> all outputs 0 at once; no ack for 10 cycles with req = 00.
REQ-037 Saturation: 16 consecutive d == 0 transactions -> dz_cnt = 15 after the 15th and still 15 after the 16th.
REQ-038 Parameter sweep: EVAL_CYCLES = 3, req = 01, n0 = 3, d0 = 2 -> ack = 01 four cycles later, q = 1, r = 1.
